// File: rtl/writeback_arbiter_if.sv
// Write-back bus between the two result producers, the arbiter and the register file port.
// The arbiter owns the slave view; the producer/consumer side owns the master view.
interface writeback_arbiter_if #(
  parameter int unsigned DEPTH = 2
) ();
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  // Fixed-latency ALU result
  logic            i_AluValid;
  logic [4:0]      i_AluRD;
  logic [31:0]     i_AluData;
  logic            o_Stall;

  // Variable-latency long unit result (valid/ready)
  logic            i_LongValid;
  logic            o_LongReady;
  logic [4:0]      i_LongRD;
  logic [31:0]     i_LongData;

  // Register file write port and hazard information
  logic [4:0]      o_RD;
  logic            o_WriteEnable;
  logic [31:0]     o_D;
  logic [31:0]     o_BusyMask;
  logic [CntW-1:0] o_Count;

  modport slave (
    input  i_AluValid, i_AluRD, i_AluData,
    input  i_LongValid, i_LongRD, i_LongData,
    output o_Stall, o_LongReady,
    output o_RD, o_WriteEnable, o_D, o_BusyMask, o_Count
  );

  modport master (
    output i_AluValid, i_AluRD, i_AluData,
    output i_LongValid, i_LongRD, i_LongData,
    input  o_Stall, o_LongReady,
    input  o_RD, o_WriteEnable, o_D, o_BusyMask, o_Count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU and long-unit results onto the single register file write port.
// Long results queue in a small FIFO; a head that waits STARVE_LIMIT cycles stalls the ALU
// for one cycle to force itself out. DEPTH must be a power of two and at least 2.
module writeback_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               i_Clock,
  input logic               i_Reset,
  writeback_arbiter_if.slave io_Wb
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned AgeW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [AgeW-1:0] LimitC = AgeW'(STARVE_LIMIT);

  // FIFO storage and control
  logic [4:0]      r_rd_mem   [DEPTH];
  logic [31:0]     r_data_mem [DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic [AgeW-1:0] r_age;

  // Registered write port
  logic [4:0]      r_rd;
  logic            r_we;
  logic [31:0]     r_d;

  logic            w_empty;
  logic            w_stall;
  logic            w_ready;
  logic            w_push;
  logic            w_alu_take;
  logic            w_pop;
  logic [4:0]      w_head_rd;
  logic [31:0]     w_head_data;
  logic [4:0]      w_rd_next;
  logic            w_we_next;
  logic [31:0]     w_d_next;
  logic [31:0]     w_busy_mask;

  assign w_empty     = (r_count == '0);
  assign w_stall     = (r_age == LimitC);
  // Ready depends only on occupancy: a pop in the same cycle does not open a full FIFO.
  assign w_ready     = ~i_Reset & (r_count < DepthC);
  assign w_push      = io_Wb.i_LongValid & w_ready;
  // rd=0 ALU results never claim the port, leaving it free for the FIFO.
  assign w_alu_take  = ~w_stall & io_Wb.i_AluValid & (io_Wb.i_AluRD != 5'd0);
  assign w_pop       = ~w_empty & (w_stall | ~w_alu_take);
  assign w_head_rd   = r_rd_mem[r_rptr];
  assign w_head_data = r_data_mem[r_rptr];

  // Choose what the write port carries next cycle: forced/idle FIFO pop, else ALU, else nothing.
  always_comb begin
    w_rd_next = 5'd0;
    w_we_next = 1'b0;
    w_d_next  = 32'd0;
    if (w_pop) begin
      w_rd_next = w_head_rd;
      w_we_next = (w_head_rd != 5'd0);
      w_d_next  = w_head_data;
    end else if (w_alu_take) begin
      w_rd_next = io_Wb.i_AluRD;
      w_we_next = 1'b1;
      w_d_next  = io_Wb.i_AluData;
    end
  end

  // Collect destinations of every occupied FIFO slot, walking from the head.
  always_comb begin
    w_busy_mask = 32'd0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PtrW-1:0] idx;
      idx = r_rptr + PtrW'(i);
      if ((CntW'(i) < r_count) && (r_rd_mem[idx] != 5'd0)) begin
        w_busy_mask[r_rd_mem[idx]] = 1'b1;
      end
    end
  end

  // FIFO payload storage; contents are only meaningful inside the occupied window.
  always_ff @(posedge i_Clock) begin
    if (w_push) begin
      r_rd_mem[r_wptr]   <= io_Wb.i_LongRD;
      r_data_mem[r_wptr] <= io_Wb.i_LongData;
    end
  end

  // FIFO pointers, occupancy, starvation age and the registered write port.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_age   <= '0;
      r_rd    <= 5'd0;
      r_we    <= 1'b0;
      r_d     <= 32'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Age measures how long the current head has been passed over.
      if (w_pop || w_empty) begin
        r_age <= '0;
      end else if (r_age != LimitC) begin
        r_age <= r_age + 1'b1;
      end
      r_rd <= w_rd_next;
      r_we <= w_we_next;
      r_d  <= w_d_next;
    end
  end

  assign io_Wb.o_Stall       = w_stall;
  assign io_Wb.o_LongReady   = w_ready;
  assign io_Wb.o_RD          = r_rd;
  assign io_Wb.o_WriteEnable = r_we;
  assign io_Wb.o_D           = r_d;
  assign io_Wb.o_BusyMask    = w_busy_mask;
  assign io_Wb.o_Count       = r_count;
endmodule
